perceptron_train_ctrl: RTL and testbench
========================================

// Module: perceptron_train_ctrl
// PURPOSE
// Sequences training of the perceptron weight table. Owns the single-port weight RAM
//   and arbitrates it between front-end prediction lookups and branch-resolve training.
// Training is a read-modify-write of one table row, with saturating +/-1 weight steps.
// Sits between the resolve stage (history/sum/prediction shift registers) and the weight RAM.
// PARAMETERS
// IDX_W      7    weight-table index width (2**IDX_W rows)
// THETA      14   training threshold on |sum|; train when |sum| <= THETA or mispredicted
// STALL_MAX  4    consecutive lookup-blocked cycles before training takes the RAM once
// PORTS
// clk        in   1    clock, all state on rising edge
// rst        in   1    asynchronous, active-low reset
// lk_req     in   1    prediction lookup wants the RAM this cycle
// lk_idx     in   IDX_W  lookup row index
// lk_gnt     out  1    lookup owns RAM this cycle (combinational)
// rs_valid   in   1    resolved-branch training request valid
// rs_ready   out  1    controller accepts request (high only in IDLE)
// rs_idx     in   IDX_W  row index used at prediction time
// rs_taken   in   1    actual outcome, 1 = taken
// rs_pred    in   1    predicted outcome
// rs_sum     in   9    signed perceptron sum used for the prediction
// rs_ghr     in   16   global history, bit j = 1 means taken
// rs_rsh     in   48   recency-stack history, bit j = 1 means taken
// mem_en     out  1    RAM enable
// mem_we     out  1    RAM write enable
// mem_addr   out  IDX_W  RAM address
// mem_wdata  out  194  row to write: {bias[1:0], rs_w[143:0], conv_w[47:0]}
// mem_rdata  in   194  read data, valid the cycle after a read enable
// busy       out  1    FSM not in IDLE
// upd_cnt    out  16   saturating count of rows written
// BEHAVIOUR
// - Reset (rst=0, async): state IDLE, captured request and row cleared, upd_cnt=0, stall_cnt=0.
// - Outputs at reset: mem_en=mem_we=0, busy=0, rs_ready=1. lk_gnt follows lk_req.
// - RAM mux:
//   - lk_gnt = lk_req & ~force.
//   - When lk_gnt is high: mem_en=1, mem_we=0, mem_addr=lk_idx.
//   - Otherwise the FSM drives the RAM. Idle RAM: mem_en=0.
// - force = (stall_cnt >= STALL_MAX) & FSM in RD or WR.
//   - stall_cnt increments each cycle that the FSM is in RD/WR and lk_gnt=1.
//   - stall_cnt clears when the FSM gets the RAM.
// - FSM:
//   - IDLE: on rs_valid & rs_ready, capture all rs_* fields.
//     need = (rs_pred != rs_taken) | (|rs_sum| <= THETA).
//     Take |sum| at 10 bits, so -256 gives 256.
//     need -> RD; otherwise stay IDLE (request dropped, no RAM access).
//   - RD: if lk_gnt=0, issue read (mem_en=1, we=0, addr=cap_idx) -> CAP; else stay.
//   - CAP: register mem_rdata into row_q -> WR. The RAM is free to lookups this cycle.
//   - WR: if lk_gnt=0, write (mem_en=1, we=1, addr=cap_idx, wdata=new_row); upd_cnt++ (sat) -> IDLE.
//     Else stay, with new_row held stable.
// - Minimum latency, accept to write: 3 cycles (IDLE->RD->CAP->WR). The next request is accepted the cycle after WR.
// - Weight update per 3-bit signed field w and history bit h:
//   - t = rs_taken ? +1 : -1.
//   - conv/rs fields: x = h ? +1 : -1; w' = sat(w + t*x) to [-3,+3]. -4 is never produced; a read -4 moves toward 0 or stays at -3.
//   - conv_w[3j+2:3j] pairs with rs_ghr[j]; rs_w[3j+2:3j] pairs with rs_rsh[j].
//   - Bias (2-bit signed): bias' = sat(bias + t) to [-1,+1].
// - Hazards:
//   - A lookup to cap_idx between RD and WR reads the pre-update row; this is permitted.
//   - Back-to-back requests to the same idx are serialised, so the second sees the first's write.
// - rst asserted mid-RMW aborts the update: no write is issued and the FSM returns to IDLE.
// TESTING
// - Reset mid-WR with lk_req=1 held -> no write with mem_we=1 ever seen; busy=0, upd_cnt=0 after release.
// - rs_pred=1, rs_taken=1, rs_sum=+40 -> no RAM access, busy stays 0, upd_cnt unchanged.
// - Mispredict, row all conv/rs w=+3, bias=+1, rs_taken=0, ghr=all 1, rsh=all 0:
//   - conv -> +2 (0x2 each), rs -> +3 (saturated), bias -> 0.
//   - Write 3 cycles after accept.
// - rs_sum=-14 correct, row w=-4 everywhere, taken=1, histories 0 -> all fields -3, bias +1 from -2 clamps to -1.
// - lk_req held high 10 cycles while FSM in RD -> training read forced on cycle STALL_MAX+1; lk_gnt=0 that cycle only.
// - Two requests to idx 5 back-to-back, each +1 step from w=0 -> final row fields +2, upd_cnt=2.

Source files
------------

// File: rtl/perceptron_train_ctrl.sv
// Perceptron weight-table training controller: arbitrates the single-port weight RAM
// between prediction lookups and a read-modify-write training sequence.
module perceptron_train_ctrl #(
  parameter int unsigned IDX_W     = 7,
  parameter int unsigned THETA     = 14,
  parameter int unsigned STALL_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lk_req,
  input  logic [IDX_W-1:0]  lk_idx,
  output logic              lk_gnt,
  input  logic              rs_valid,
  output logic              rs_ready,
  input  logic [IDX_W-1:0]  rs_idx,
  input  logic              rs_taken,
  input  logic              rs_pred,
  input  logic [8:0]        rs_sum,
  input  logic [15:0]       rs_ghr,
  input  logic [47:0]       rs_rsh,
  output logic              mem_en,
  output logic              mem_we,
  output logic [IDX_W-1:0]  mem_addr,
  output logic [193:0]      mem_wdata,
  input  logic [193:0]      mem_rdata,
  output logic              busy,
  output logic [15:0]       upd_cnt
);

  localparam int unsigned ROW_W    = 194;
  localparam int unsigned GHR_W    = 16;
  localparam int unsigned RSH_W    = 48;
  localparam int unsigned CONV_LSB = 0;
  localparam int unsigned RS_LSB   = 48;
  localparam int unsigned BIAS_LSB = 192;
  localparam int unsigned STALL_W  = $clog2(STALL_MAX + 1);

  typedef enum logic [1:0] {IDLE, RD, CAP, WR} state_t;

  state_t             state_q, state_n;
  logic [IDX_W-1:0]   cap_idx;
  logic               cap_taken;
  logic [GHR_W-1:0]   cap_ghr;
  logic [RSH_W-1:0]   cap_rsh;
  logic [ROW_W-1:0]   row_q;
  logic [ROW_W-1:0]   new_row;
  logic [STALL_W-1:0] stall_q;
  logic [9:0]         sum_ext;
  logic [9:0]         abs_sum;
  logic               need;
  logic               fsm_rw;
  logic               force_fsm;
  logic               cap_en;
  logic               row_en;
  logic               wr_fire;

  // 3-bit weight step of +/-1, saturated to [-3,+3]; -4 is never produced
  function automatic logic [2:0] step_w(input logic [2:0] w, input logic up);
    logic [3:0] s;
    s = {w[2], w} + (up ? 4'b0001 : 4'b1111);
    if (!s[3] && (s > 4'd3))          return 3'b011;
    else if (s[3] && (s < 4'b1101))   return 3'b101;
    else                              return s[2:0];
  endfunction

  // 2-bit bias step of +/-1, saturated to [-1,+1]
  function automatic logic [1:0] step_b(input logic [1:0] b, input logic up);
    logic [2:0] s;
    s = {b[1], b} + (up ? 3'b001 : 3'b111);
    if (!s[2] && (s > 3'd1))          return 2'b01;
    else if (s[2] && (s < 3'b111))    return 2'b11;
    else                              return s[1:0];
  endfunction

  // |sum| taken at 10 bits so that -256 stays 256
  always_comb begin
    sum_ext = {rs_sum[8], rs_sum};
    abs_sum = sum_ext[9] ? (10'd0 - sum_ext) : sum_ext;
    need    = (rs_pred != rs_taken) || (abs_sum <= 10'(THETA));
  end

  // Updated row: product t*x is +1 exactly when outcome and history bit agree
  always_comb begin
    new_row = row_q;
    for (int j = 0; j < GHR_W; j++)
      new_row[CONV_LSB + 3*j +: 3] = step_w(row_q[CONV_LSB + 3*j +: 3], cap_taken ~^ cap_ghr[j]);
    for (int j = 0; j < RSH_W; j++)
      new_row[RS_LSB + 3*j +: 3] = step_w(row_q[RS_LSB + 3*j +: 3], cap_taken ~^ cap_rsh[j]);
    new_row[BIAS_LSB +: 2] = step_b(row_q[BIAS_LSB +: 2], cap_taken);
  end

  // RAM arbitration and next-state logic
  always_comb begin
    state_n   = state_q;
    cap_en    = 1'b0;
    row_en    = 1'b0;
    wr_fire   = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = cap_idx;
    mem_wdata = new_row;
    fsm_rw    = (state_q == RD) || (state_q == WR);
    force_fsm = fsm_rw && (stall_q >= STALL_W'(STALL_MAX));
    lk_gnt    = lk_req && !force_fsm;
    rs_ready  = (state_q == IDLE);
    busy      = (state_q != IDLE);

    if (lk_gnt) begin
      mem_en   = 1'b1;
      mem_addr = lk_idx;
    end

    case (state_q)
      IDLE: begin
        if (rs_valid) begin
          cap_en = 1'b1;
          if (need) state_n = RD;
        end
      end
      RD: begin
        if (!lk_gnt) begin
          mem_en  = 1'b1;
          state_n = CAP;
        end
      end
      CAP: begin
        row_en  = 1'b1;
        state_n = WR;
      end
      WR: begin
        if (!lk_gnt) begin
          mem_en  = 1'b1;
          mem_we  = 1'b1;
          wr_fire = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cap_idx   <= '0;
      cap_taken <= 1'b0;
      cap_ghr   <= '0;
      cap_rsh   <= '0;
      row_q     <= '0;
      upd_cnt   <= '0;
      stall_q   <= '0;
    end else begin
      state_q <= state_n;
      if (cap_en) begin
        cap_idx   <= rs_idx;
        cap_taken <= rs_taken;
        cap_ghr   <= rs_ghr;
        cap_rsh   <= rs_rsh;
      end
      if (row_en) row_q <= mem_rdata;
      if (wr_fire && (upd_cnt != 16'hFFFF)) upd_cnt <= upd_cnt + 16'd1;
      // Stall count tracks lookups starving an RD/WR; cleared once the FSM gets the RAM
      if (fsm_rw) begin
        if (lk_gnt) begin
          if (stall_q < STALL_W'(STALL_MAX)) stall_q <= stall_q + STALL_W'(1);
        end else begin
          stall_q <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_perceptron_train_ctrl.sv
// Directed bench for perceptron_train_ctrl with a behavioural single-port weight RAM.
module tb_perceptron_train_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         lk_req;
  logic [6:0]   lk_idx;
  logic         lk_gnt;
  logic         rs_valid;
  logic         rs_ready;
  logic [6:0]   rs_idx;
  logic         rs_taken;
  logic         rs_pred;
  logic [8:0]   rs_sum;
  logic [15:0]  rs_ghr;
  logic [47:0]  rs_rsh;
  logic         mem_en;
  logic         mem_we;
  logic [6:0]   mem_addr;
  logic [193:0] mem_wdata;
  logic [193:0] mem_rdata;
  logic         busy;
  logic [15:0]  upd_cnt;

  logic [193:0] ram [0:127];
  logic         bd_we;
  logic [6:0]   bd_addr;
  logic [193:0] bd_data;
  int           n_wr  = 0;
  int           n_mem = 0;
  int           n_vec = 0;
  int           n_err = 0;
  int           wr0;
  int           mem0;

  always #5 clk = ~clk;

  perceptron_train_ctrl dut (
    .clk(clk), .rst(rst),
    .lk_req(lk_req), .lk_idx(lk_idx), .lk_gnt(lk_gnt),
    .rs_valid(rs_valid), .rs_ready(rs_ready), .rs_idx(rs_idx),
    .rs_taken(rs_taken), .rs_pred(rs_pred), .rs_sum(rs_sum),
    .rs_ghr(rs_ghr), .rs_rsh(rs_rsh),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .upd_cnt(upd_cnt)
  );

  // Single-port RAM, read data one cycle after enable; backdoor port for preload
  always @(posedge clk) begin
    if (bd_we) begin
      ram[bd_addr] <= bd_data;
    end else if (mem_en) begin
      n_mem <= n_mem + 1;
      if (mem_we) begin
        ram[mem_addr] <= mem_wdata;
        n_wr <= n_wr + 1;
      end else begin
        mem_rdata <= ram[mem_addr];
      end
    end
  end

  function automatic logic [193:0] mk_row(input logic [1:0] b, input logic [2:0] cf, input logic [2:0] rf);
    logic [193:0] r;
    r = '0;
    r[193:192] = b;
    for (int j = 0; j < 48; j++) r[48 + 3*j +: 3] = rf;
    for (int j = 0; j < 16; j++) r[3*j +: 3] = cf;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [193:0] obs, input logic [193:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic bd_write(input logic [6:0] a, input logic [193:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    step();
    bd_we = 1'b0;
  endtask

  task automatic send(input logic [6:0] idx, input logic taken, input logic pred,
                      input logic [8:0] sum, input logic [15:0] ghr, input logic [47:0] rsh);
    rs_idx = idx; rs_taken = taken; rs_pred = pred; rs_sum = sum; rs_ghr = ghr; rs_rsh = rsh;
    rs_valid = 1'b1;
    #1;
    chk("accept_ready", rs_ready, 1'b1);
    @(posedge clk);
    #1;
    rs_valid = 1'b0;
    #1;
  endtask

  task automatic run_until_idle();
    int k;
    k = 0;
    while (busy && k < 20) begin
      step();
      k++;
    end
    if (busy) chk("idle_timeout", busy, 1'b0);
  endtask

  initial begin
    rst = 1'b0; lk_req = 1'b0; lk_idx = '0; rs_valid = 1'b0; rs_idx = '0;
    rs_taken = 1'b0; rs_pred = 1'b0; rs_sum = '0; rs_ghr = '0; rs_rsh = '0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    #12;
    // Reset values; lookup passes straight through
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", rs_ready, 1'b1);
    chk("rst_upd", upd_cnt, 16'd0);
    chk("rst_mem_we", mem_we, 1'b0);
    lk_req = 1'b1; lk_idx = 7'd33;
    #1;
    chk("rst_lk_gnt", lk_gnt, 1'b1);
    chk("rst_lk_addr", mem_addr, 7'd33);
    lk_req = 1'b0;
    #1;
    chk("rst_mem_en", mem_en, 1'b0);

    bd_write(7'd3,  mk_row(2'b01, 3'b011, 3'b011));
    bd_write(7'd9,  mk_row(2'b10, 3'b100, 3'b100));
    bd_write(7'd20, '0);
    bd_write(7'd5,  '0);
    bd_write(7'd30, '0);
    rst = 1'b1;
    step();

    // Confident correct predictions: no training, no RAM access
    mem0 = n_mem;
    send(7'd3, 1'b1, 1'b1, 9'd40, 16'h0, 48'h0);
    chk("notrain40_busy", busy, 1'b0);
    send(7'd3, 1'b1, 1'b1, 9'h1F1, 16'h0, 48'h0);
    chk("notrain_m15_busy", busy, 1'b0);
    send(7'd3, 0, 0, 9'h100, 16'h0, 48'h0);
    chk("notrain_m256_busy", busy, 1'b0);
    step();
    chk("notrain_no_mem", n_mem, mem0);
    chk("notrain_upd", upd_cnt, 16'd0);

    // Mispredict on saturated row: write lands 3 cycles after accept
    send(7'd3, 1'b0, 1'b1, 9'd100, 16'hFFFF, 48'h0);
    chk("mp_rd_busy", busy, 1'b1);
    chk("mp_rd_en", mem_en, 1'b1);
    chk("mp_rd_we", mem_we, 1'b0);
    chk("mp_rd_addr", mem_addr, 7'd3);
    step();
    chk("mp_cap_en", mem_en, 1'b0);
    step();
    chk("mp_wr_we", mem_we, 1'b1);
    chk("mp_wr_addr", mem_addr, 7'd3);
    chk("mp_wr_data", mem_wdata, mk_row(2'b00, 3'b010, 3'b011));
    step();
    chk("mp_idle", busy, 1'b0);
    chk("mp_upd", upd_cnt, 16'd1);
    chk("mp_ram", ram[3], mk_row(2'b00, 3'b010, 3'b011));

    // |sum| at threshold on a -4 row: everything lands on -3, bias clamps to -1
    send(7'd9, 1'b1, 1'b1, 9'h1F2, 16'h0, 48'h0);
    chk("th_busy", busy, 1'b1);
    run_until_idle();
    chk("th_ram", ram[9], mk_row(2'b11, 3'b101, 3'b101));
    chk("th_upd", upd_cnt, 16'd2);

    // Lookups hammering the RAM: forced read then forced write after 4 blocked cycles
    send(7'd20, 1'b1, 1'b0, 9'd0, 16'h0, 48'h0);
    lk_req = 1'b1; lk_idx = 7'd7;
    #1;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("stall_gnt%0d", i), lk_gnt, (i == 4) ? 1'b0 : 1'b1);
      if (i == 4) begin
        chk("stall_rd_en", mem_en, 1'b1);
        chk("stall_rd_we", mem_we, 1'b0);
        chk("stall_rd_addr", mem_addr, 7'd20);
      end
      step();
    end
    lk_req = 1'b0;
    #1;
    chk("stall_wr_we", mem_we, 1'b1);
    chk("stall_wr_data", mem_wdata, mk_row(2'b01, 3'b111, 3'b111));
    step();
    chk("stall_idle", busy, 1'b0);
    chk("stall_upd", upd_cnt, 16'd3);

    // Back-to-back requests to the same row serialise through the RAM
    send(7'd5, 1'b1, 1'b0, 9'd0, 16'hFFFF, 48'hFFFF_FFFF_FFFF);
    run_until_idle();
    send(7'd5, 1'b1, 1'b0, 9'd0, 16'hFFFF, 48'hFFFF_FFFF_FFFF);
    run_until_idle();
    chk("b2b_ram", ram[5], mk_row(2'b01, 3'b010, 3'b010));
    chk("b2b_upd", upd_cnt, 16'd5);

    // Reset in WR while a lookup blocks the write: update is abandoned
    send(7'd30, 1'b1, 1'b0, 9'd0, 16'h0, 48'h0);
    step();
    lk_req = 1'b1; lk_idx = 7'd7;
    step();
    chk("rstwr_busy", busy, 1'b1);
    chk("rstwr_we", mem_we, 1'b0);
    wr0 = n_wr;
    rst = 1'b0;
    #1;
    chk("rstwr_busy_now", busy, 1'b0);
    step();
    step();
    rst = 1'b1;
    step();
    step();
    step();
    chk("rstwr_no_write", n_wr, wr0);
    chk("rstwr_idle", busy, 1'b0);
    chk("rstwr_upd", upd_cnt, 16'd0);
    chk("rstwr_ram", ram[30], 194'd0);
    lk_req = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
